// File: rtl/dark_window_ctrl.sv
// ============================================================================
// Module   : dark_window_ctrl
// Brief    : Raster sequencer forming per-channel 3x3 windows for the dark-channel
//            unit and re-aligning its registered result with position flags.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dark_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [71:0] win_r,
  output logic [71:0] win_g,
  output logic [71:0] win_b,
  output logic        win_valid,
  input  logic [7:0]  dark_in,
  output logic [7:0]  dark_out,
  output logic        dark_valid,
  output logic        dark_sof,
  output logic        dark_eol,
  output logic        frame_done,
  output logic        busy
);

  localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
  localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   col_q, row_q;
  logic          ptr_q;
  logic [23:0]   lb0 [IMG_W];
  logic [23:0]   lb1 [IMG_W];
  logic [71:0]   win_r_q, win_g_q, win_b_q;
  logic          win_valid_q, win_sof_q, win_eol_q;
  logic [2:0]    dly_q [LAT];
  logic [7:0]    dark_q;
  logic          dark_valid_q, dark_sof_q, dark_eol_q;

  logic          accept_w, col_last_w, dly_busy_w;
  logic [AW-1:0] addr_w;
  logic [23:0]   rd0_w, rd1_w, top_w, mid_w, pix_w;
  logic [2:0]    tap_w;

  assign accept_w   = pix_valid & pix_ready;
  assign col_last_w = (col_q == COL_LAST);
  assign addr_w     = col_q[AW-1:0];
  assign pix_w      = {pix_r, pix_g, pix_b};
  assign rd0_w      = lb0[addr_w];
  assign rd1_w      = lb1[addr_w];
  // ptr_q names the buffer holding row-1; the other holds row-2 and is overwritten.
  assign top_w      = ptr_q ? rd0_w : rd1_w;
  assign mid_w      = ptr_q ? rd1_w : rd0_w;
  assign tap_w      = dly_q[LAT-1];

  always_comb begin
    dly_busy_w = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      dly_busy_w = dly_busy_w | dly_q[i][2];
    end
  end

  always_comb begin
    state_d    = state_q;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && col_last_w && row_q == 12'd1) state_d = S_RUN;
      end
      S_RUN: begin
        pix_ready = 1'b1;
        if (pix_valid && col_last_w && row_q == ROW_LAST) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!win_valid_q && !dly_busy_w) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= 12'd0;
      row_q   <= 12'd0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        col_q <= 12'd0;
        row_q <= 12'd0;
        ptr_q <= 1'b0;
      end else if (accept_w) begin
        if (col_last_w) begin
          col_q <= 12'd0;
          row_q <= row_q + 12'd1;
          ptr_q <= ~ptr_q;
        end else begin
          col_q <= col_q + 12'd1;
        end
      end
    end
  end

  // Combinational read above sees the pre-edge contents, giving read-old-data.
  always_ff @(posedge clk) begin
    if (accept_w) begin
      if (ptr_q) lb0[addr_w] <= pix_w;
      else       lb1[addr_w] <= pix_w;
    end
  end

  function automatic logic [71:0] shift_win(input logic [71:0] w, input logic [7:0] t,
                                            input logic [7:0] m, input logic [7:0] p);
    return {w[63:48], t, w[39:24], m, w[15:0], p};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r_q     <= 72'd0;
      win_g_q     <= 72'd0;
      win_b_q     <= 72'd0;
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_eol_q   <= 1'b0;
    end else begin
      if (accept_w && state_q == S_RUN) begin
        win_r_q <= shift_win(win_r_q, top_w[23:16], mid_w[23:16], pix_r);
        win_g_q <= shift_win(win_g_q, top_w[15:8],  mid_w[15:8],  pix_g);
        win_b_q <= shift_win(win_b_q, top_w[7:0],   mid_w[7:0],   pix_b);
      end
      win_valid_q <= accept_w && (state_q == S_RUN) && (col_q >= 12'd2);
      win_sof_q   <= (row_q == 12'd2) && (col_q == 12'd2);
      win_eol_q   <= col_last_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dly_q[i] <= 3'd0;
      dark_q       <= 8'd0;
      dark_valid_q <= 1'b0;
      dark_sof_q   <= 1'b0;
      dark_eol_q   <= 1'b0;
    end else begin
      dly_q[0] <= {win_valid_q, win_valid_q & win_sof_q, win_valid_q & win_eol_q};
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      if (tap_w[2]) dark_q <= dark_in;
      dark_valid_q <= tap_w[2];
      dark_sof_q   <= tap_w[1];
      dark_eol_q   <= tap_w[0];
    end
  end

  assign win_r      = win_r_q;
  assign win_g      = win_g_q;
  assign win_b      = win_b_q;
  assign win_valid  = win_valid_q;
  assign dark_out   = dark_q;
  assign dark_valid = dark_valid_q;
  assign dark_sof   = dark_sof_q;
  assign dark_eol   = dark_eol_q;

endmodule

`default_nettype wire

// File: tb/tb_dark_window_ctrl.sv
// ============================================================================
// Module   : tb_dark_window_ctrl
// Brief    : Self-checking bench for dark_window_ctrl (4x4 frames plus a 5x3 packing case).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dark_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [7:0]  pr = 8'd0, pg = 8'd0, pb = 8'd0, dark_in;
  logic        pix_ready, win_valid, dark_valid, dark_sof, dark_eol, frame_done, busy;
  logic [71:0] win_r, win_g, win_b;
  logic [7:0]  dark_out;

  logic        start5 = 1'b0, pv5 = 1'b0;
  logic [23:0] d5 = 24'd0;
  logic [7:0]  dark_in5 = 8'd0;
  logic        ready5, wv5, dv5, dsof5, deol5, done5, busy5;
  logic [71:0] wr5, wg5, wb5;
  logic [7:0]  dout5;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dark_window_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pr), .pix_g(pg), .pix_b(pb), .win_r(win_r), .win_g(win_g), .win_b(win_b),
    .win_valid(win_valid), .dark_in(dark_in), .dark_out(dark_out), .dark_valid(dark_valid),
    .dark_sof(dark_sof), .dark_eol(dark_eol), .frame_done(frame_done), .busy(busy)
  );

  dark_window_ctrl #(.IMG_W(5), .IMG_H(3), .LAT(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .pix_valid(pv5), .pix_ready(ready5),
    .pix_r(d5[23:16]), .pix_g(d5[15:8]), .pix_b(d5[7:0]), .win_r(wr5), .win_g(wg5), .win_b(wb5),
    .win_valid(wv5), .dark_in(dark_in5), .dark_out(dout5), .dark_valid(dv5),
    .dark_sof(dsof5), .dark_eol(deol5), .frame_done(done5), .busy(busy5)
  );

  function automatic logic [7:0] min27(input logic [71:0] a, input logic [71:0] b, input logic [71:0] c);
    logic [7:0] m = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      if (a[i*8 +: 8] < m) m = a[i*8 +: 8];
      if (b[i*8 +: 8] < m) m = b[i*8 +: 8];
      if (c[i*8 +: 8] < m) m = c[i*8 +: 8];
    end
    return m;
  endfunction

  // Stand-in dark-channel unit: one registered stage (LAT = 1).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dark_in <= 8'd0;
    else        dark_in <= min27(win_r, win_g, win_b);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event absent or unexpected (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [71:0] r; logic [71:0] g; logic [71:0] b; } win_t;
  typedef struct { int cyc; logic [7:0] v; bit sof; bit eol; bit last; } dark_t;

  win_t        wq[$];
  dark_t       dq[$];
  logic [23:0] fr [H][W];
  int          acc22 = -1, exp_done = -1;
  int          got_n = 0, done_cnt = 0, first_dark = -1, last_dark = -1, done_cyc = -1;
  int          got_v [16];
  logic [15:0] got_sofv = 16'd0, got_eolv = 16'd0;
  int          lit_d [4] = '{0, 1, 4, 5};

  function automatic logic [23:0] pix_of(input int mode, input int r, input int c);
    int v = r * 4 + c;
    if (mode == 0) return {8'(v), 8'(v), 8'(v)};
    return {8'(v * 3 + 7), 8'(200 - v * 5), 8'(v * 11 + 1)};
  endfunction

  // Called at the negedge before the accepting edge; cyc is that edge's cycle.
  task automatic push_accept(input int idx, input logic [23:0] px);
    int r, c, pos;
    win_t w;
    dark_t d;
    logic [7:0] mn;
    r = idx / W;
    c = idx % W;
    fr[r][c] = px;
    if (idx == 2 * W + 2) acc22 = cyc;
    if (r >= 2 && c >= 2) begin
      w.cyc = cyc + 1;
      w.r = 72'd0; w.g = 72'd0; w.b = 72'd0;
      mn = 8'hFF;
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = 0; dc < 3; dc++) begin
          pos = (8 - (dr * 3 + dc)) * 8;
          w.r[pos +: 8] = fr[r-2+dr][c-2+dc][23:16];
          w.g[pos +: 8] = fr[r-2+dr][c-2+dc][15:8];
          w.b[pos +: 8] = fr[r-2+dr][c-2+dc][7:0];
        end
      end
      mn = min27(w.r, w.g, w.b);
      wq.push_back(w);
      d.cyc  = cyc + 3;
      d.v    = mn;
      d.sof  = (r == 2 && c == 2);
      d.eol  = (c == W - 1);
      d.last = (idx == W * H - 1);
      dq.push_back(d);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    win_t  we;
    dark_t de;
    if (rst_n) begin
      if (win_valid) begin
        if (wq.size() == 0) miss("win_spurious");
        else begin
          we = wq.pop_front();
          chk("win_cyc", 72'(cyc), 72'(we.cyc));
          chk("win_r", win_r, we.r);
          chk("win_g", win_g, we.g);
          chk("win_b", win_b, we.b);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        miss("win_missing");
        void'(wq.pop_front());
      end

      if (dark_valid) begin
        if (dq.size() == 0) miss("dark_spurious");
        else begin
          de = dq.pop_front();
          chk("dark_cyc", 72'(cyc), 72'(de.cyc));
          chk("dark_out", dark_out, de.v);
          chk("dark_sof", dark_sof, de.sof);
          chk("dark_eol", dark_eol, de.eol);
          if (got_n < 16) begin
            got_v[got_n]    = int'(dark_out);
            got_sofv[got_n] = dark_sof;
            got_eolv[got_n] = dark_eol;
          end
          got_n++;
          if (first_dark < 0) first_dark = cyc;
          last_dark = cyc;
          if (de.last) exp_done = cyc + 1;
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        miss("dark_missing");
        void'(dq.pop_front());
      end

      if (frame_done) begin
        chk("frame_done_cyc", 72'(cyc), 72'(exp_done));
        done_cyc = cyc;
        done_cnt++;
      end else if (exp_done == cyc) begin
        miss("frame_done_missing");
      end
    end
  end

  int          w5_cnt = 0;
  logic [71:0] w5a_r, w5a_g, w5a_b, w5b_r;
  always @(negedge clk) begin
    if (rst_n && wv5) begin
      if (w5_cnt == 0) begin w5a_r = wr5; w5a_g = wg5; w5a_b = wb5; end
      if (w5_cnt == 1) w5b_r = wr5;
      w5_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input int mode, input bit bubble, input bit start_mid, input int abort_after);
    int sent, t;
    bit v;
    logic [23:0] px;
    got_n = 0; got_sofv = 16'd0; got_eolv = 16'd0; done_cnt = 0; first_dark = -1; done_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    sent = 0;
    t = 0;
    while (sent < W * H && t < 500) begin
      if (abort_after >= 0 && sent == abort_after) break;
      v  = bubble ? (t % 2 == 0) : 1'b1;
      px = pix_of(mode, sent / W, sent % W);
      pix_valid    = v;
      {pr, pg, pb} = v ? px : 24'hEEEEEE;
      start        = start_mid && (sent == 13);
      if (v && pix_ready) begin
        push_accept(sent, px);
        sent++;
      end
      t++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (t >= 500) miss("frame_timeout");
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) miss("busy_stuck");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_ramp_lits();
    chk("lit_count", 72'(got_n), 72'd4);
    for (int i = 0; i < 4; i++) chk("lit_dark", 72'(got_v[i]), 72'(lit_d[i]));
    chk("lit_sof", got_sofv[3:0], 4'b0001);
    chk("lit_eol", got_eolv[3:0], 4'b1010);
    chk("lit_latency", 72'(first_dark - acc22), 72'd3);
    chk("lit_done_gap", 72'(done_cyc - last_dark), 72'd1);
    chk("lit_done_count", 72'(done_cnt), 72'd1);
  endtask

  logic [71:0] lit5a, lit5b;

  initial begin
    // reset held: inputs toggling must leave every output at zero
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start     = i[0];
      pix_valid = ~i[0];
      #1;
      chk("reset_ctrl", {pix_ready, busy, win_valid, dark_valid, dark_sof, dark_eol, frame_done, dark_out}, 0);
      chk("reset_win", win_r | win_g | win_b, 0);
    end
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 1'b0, 1'b0, -1);
    wait_idle();
    check_ramp_lits();

    run_frame(0, 1'b1, 1'b0, -1);
    wait_idle();
    check_ramp_lits();

    // pix_valid while idle must not be accepted
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1;
      {pr, pg, pb} = 24'h123456;
      @(negedge clk);
      chk("ready_idle", pix_ready, 0);
    end
    pix_valid = 1'b0;

    run_frame(1, 1'b0, 1'b1, -1);
    wait_idle();
    chk("color_count", 72'(got_n), 72'd4);
    chk("color_done_count", 72'(done_cnt), 72'd1);

    // mid-frame reset after 9 accepts
    run_frame(0, 1'b0, 1'b0, 9);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {pix_ready, busy, win_valid, dark_valid, dark_sof, dark_eol, frame_done, dark_out}, 0);
    chk("abort_win", win_r | win_g | win_b, 0);
    wq.delete();
    dq.delete();
    exp_done = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b0, 1'b0, -1);
    wait_idle();
    check_ramp_lits();

    // 5-wide window packing: centre (1,1) holds 200, everything else 10
    lit5a = {{4{8'd10}}, 8'd200, {4{8'd10}}};
    lit5b = {{3{8'd10}}, 8'd200, {5{8'd10}}};
    @(negedge clk); start5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pv5 = 1'b1;
      d5  = (i == 6) ? {3{8'd200}} : {3{8'd10}};
      if (!ready5) miss("ready5");
      @(negedge clk);
    end
    pv5 = 1'b0;
    begin
      int k = 0;
      while (busy5 && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (busy5) miss("busy5_stuck");
    end
    chk("win5_count", 72'(w5_cnt), 72'd3);
    chk("win5_first_r", w5a_r, lit5a);
    chk("win5_first_g", w5a_g, lit5a);
    chk("win5_first_b", w5a_b, lit5a);
    chk("win5_second_r", w5b_r, lit5b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dark_window_ctrl.md
Name: dark_window_ctrl

Overview:
- Raster-scan sequencer for the 3x3 dark-channel datapath.
- Accepts an RGB pixel stream (valid/ready), buffers two lines per channel and forms 3x3 windows per channel.
- Drives the windows to the dark-channel unit and re-aligns its registered result with position flags.
- Sits between the frame reader and the transmission-estimation stage; handles one frame per start pulse.

Parameters:
- IMG_W, 640, pixels per line; legal range 3..4095.
- IMG_H, 480, lines per frame; legal range 3..4095.
- LAT, 1, clock latency of the attached dark-channel unit from window to result; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  controller accepts pixel.
- pix_r / pix_g / pix_b  in  8 each  pixel channels.
- win_r / win_g / win_b  out  72 each  window, packed a..i in bits [71:64] down to [7:0]:
  - a,b,c = top row, left to right; d,e,f = middle row; g,h,i = bottom row.
  - e = window centre.
- win_valid  out  1  windows valid this cycle.
- dark_in  in  8  result returned from the dark-channel unit.
- dark_out  out  8  registered dark value.
- dark_valid  out  1  dark_out valid.
- dark_sof  out  1  first output of frame; qualified by dark_valid.
- dark_eol  out  1  last output of a line; qualified by dark_valid.
- frame_done  out  1  one-cycle pulse after the last dark_valid of the frame.
- busy  out  1  high from start until frame_done.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; all counters and the delay line clear.
  - pix_ready, win_valid, dark_valid, dark_sof, dark_eol, frame_done and busy are 0.
  - dark_out, win_r, win_g and win_b are 0; line-buffer contents are don't-care.
  - Reset mid-frame abandons the frame; no frame_done is issued.
- Accept = pix_valid & pix_ready, sampled at the rising edge.
- FSM states: IDLE, FILL, RUN, FLUSH, DONE.
  - IDLE: pix_ready=0. start moves to FILL and clears col/row counters. start in any other state is ignored.
  - FILL (rows 0..1): pix_ready=1. Each accepted pixel is written to the line buffers. col advances and wraps at IMG_W-1 with row+1. Leaving row 1 moves to RUN.
  - RUN (rows 2..IMG_H-1): pix_ready=1. On accept, the column {linebuf row-2, linebuf row-1, incoming pixel} is shifted into the 3-column window registers, and the incoming pixel is written to the line buffer.
    - win_valid is asserted in the cycle after an accept with col>=2. That window's centre is (row-1, col-1).
    - Accepting (IMG_H-1, IMG_W-1) moves to FLUSH.
  - FLUSH: pix_ready=0. Waits until the delay line is empty, then moves to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- Window column shift restarts on every line: the first two accepts of a line (col 0,1) prime the window without asserting win_valid.
- Delay line: win_valid, SOF and EOL flags are delayed LAT cycles.
  - At the tap, dark_out <= dark_in and dark_valid <= tap_valid.
  - Total latency is LAT+2 cycles from the accepting edge to dark_valid (3 for LAT=1).
- dark_sof is set for the window centred (1,1). dark_eol is set for windows with centre column IMG_W-2.
- Output count per frame is exactly (IMG_W-2)*(IMG_H-2). Border pixels produce no output.
- pix_valid bubbles: win_valid and dark_valid gap correspondingly. No output backpressure exists; downstream must always accept.
- pix_valid while pix_ready=0 has no effect. Pixel data while pix_valid=0 is ignored.
- Line buffers: two per channel, IMG_W x 8 bits, addressed by col. A rotating pointer selects row-2/row-1 with no data copy. Read and write to the same address in the same cycle must return the old data.
- Counter widths: 12 bits each. No arithmetic overflow is possible within the legal parameter range.

Test Plan:
- Reset values: hold rst_n=0 and toggle start/pix_valid -> all outputs 0; pix_ready=0; busy=0.
- Ramp frame: IMG_W=IMG_H=4, LAT=1, team dark-channel unit attached, pixel value = row*4+col on all channels, continuous valid:
  - dark_valid fires 4 times with dark_out = 0,1,4,5.
  - dark_sof on the first output; dark_eol on the 2nd and 4th outputs.
  - frame_done one cycle after the 4th output; first dark_valid 3 cycles after the accept of (2,2).
- Bubbles: same frame with pix_valid toggling 1,0,1,0 -> identical dark_out sequence and flags; no spurious win_valid.
- Window packing: IMG_W=5, pixel (1,1)=200 elsewhere 10 -> window centred (1,1) has win_r[39:32]=200 and other bytes 10.
- Ignored inputs: start pulsed during RUN -> no effect, still 4 outputs. pix_valid=1 in IDLE -> pix_ready=0 and nothing accepted.
- Reset mid-frame: assert rst_n=0 after 9 accepts -> outputs clear immediately, no frame_done. A subsequent start plus a full frame yields the correct 4 outputs.
